// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM state encoding and Wishbone cycle-type constants for the slave controller.
package wb_pkg;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADR  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } state_t;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
endpackage

// File: rtl/wb_wait_cnt.sv
// wb_wait_cnt: loadable wait-state down-counter; done flags the final wait cycle.
module wb_wait_cnt
    import wb_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_dec,
    input  logic [CW-1:0] i_val,
    output logic          o_done
);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end
    assign o_done = r_cnt <= CW'(1);
endmodule

// File: rtl/wb_slave_ctrl.sv
// wb_slave_ctrl: Wishbone B4 classic slave bridging to a synchronous memory with wait states.
// Define WB_BURST_EN to enable incrementing bursts driven by wb_cti_i.
module wb_slave_ctrl
    import wb_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int MEM_BYTES   = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [2:0]      wb_cti_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic [AW-1:0]   mem_adr_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic            mem_we_o,
    output logic            mem_re_o,
    input  logic [DW-1:0]   mem_rdata_i
);
    localparam int SW = DW / 8;
    localparam logic [AW:0]   LIM  = (AW+1)'(MEM_BYTES);
    localparam logic [AW-1:0] STEP = AW'(SW);
    localparam logic [3:0]    WC   = 4'(WAIT_CYCLES);

    state_t        r_state, w_next;
    logic [AW-1:0] r_adr;
    logic [SW-1:0] r_sel;
    logic [DW-1:0] r_dat;
    logic          r_we;
    logic          w_req, w_oor, w_done, w_burst;

    assign w_req = wb_cyc_i & wb_stb_i;
    assign w_oor = {1'b0, r_adr} >= LIM;

`ifdef WB_BURST_EN
    logic [2:0] r_cti;
    assign w_burst = w_req && r_cti == CTI_INCR;
`else
    logic w_unused;
    assign w_unused = ^wb_cti_i;
    assign w_burst  = 1'b0;
`endif

    wb_wait_cnt #(.CW(4)) u_wait (
        .clk    (clk),
        .reset  (reset),
        .i_load (r_state == ST_ADR),
        .i_dec  (r_state == ST_WAIT),
        .i_val  (WC),
        .o_done (w_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = w_req ? ST_ADR : ST_IDLE;
            ST_ADR:  w_next = !wb_cyc_i ? ST_IDLE : w_oor ? ST_ERR : (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: w_next = !wb_cyc_i ? ST_IDLE : w_done ? ST_RESP : ST_WAIT;
            ST_RESP: w_next = w_burst ? ST_ADR : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Strobes ignore cyc: once issued in ADR a write is never retracted.
    always_comb begin
        wb_ack_o = r_state == ST_RESP && wb_cyc_i;
        wb_err_o = r_state == ST_ERR && wb_cyc_i;
        wb_dat_o = (wb_ack_o && !r_we) ? mem_rdata_i : '0;
        mem_we_o = r_state == ST_ADR && !w_oor && r_we;
        mem_re_o = r_state == ST_ADR && !w_oor && !r_we;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_adr <= '0;
            r_sel <= '0;
            r_dat <= '0;
            r_we  <= 1'b0;
`ifdef WB_BURST_EN
            r_cti <= CTI_CLASSIC;
`endif
        end else if (r_state == ST_IDLE && w_req) begin
            r_adr <= wb_adr_i;
            r_sel <= wb_sel_i;
            r_dat <= wb_dat_i;
            r_we  <= wb_we_i;
`ifdef WB_BURST_EN
            r_cti <= wb_cti_i;
`endif
        end else if (r_state == ST_RESP && w_burst) begin
            r_adr <= r_adr + STEP;
            r_sel <= wb_sel_i;
            r_dat <= wb_dat_i;
            r_we  <= wb_we_i;
`ifdef WB_BURST_EN
            r_cti <= wb_cti_i;
`endif
        end
    end

    assign mem_adr_o   = r_adr;
    assign mem_be_o    = r_sel;
    assign mem_wdata_o = r_dat;
endmodule

// File: tb/tb_wb_slave_ctrl.sv
// tb_wb_slave_ctrl: two slaves (0 and 3 wait states) on one shared bus, checked against hand-computed vectors.
module tb_wb_slave_ctrl;
    import wb_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] dato;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat = '0, rdata = '0;
    logic [3:0]  sel = '0;
    logic [2:0]  cti = CTI_CLASSIC;

    logic [31:0] dat_o[2], madr[2], mwd[2];
    logic [3:0]  mbe[2];
    logic        ack[2], err[2], mwe[2], mre[2];

    int n_cmp = 0, n_fail = 0;
    int ack_n[2], ack_c[2], err_n[2], err_c[2], str_n[2], str_c[2], both[2], leak[2];
    logic [31:0] str_adr[2], dato_v[2];
    logic        str_we[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_slave_ctrl #(.DW(32), .AW(32), .WAIT_CYCLES(g * 3), .MEM_BYTES(4096)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .wb_cyc_i    (cyc),
            .wb_stb_i    (stb),
            .wb_we_i     (we),
            .wb_adr_i    (adr),
            .wb_sel_i    (sel),
            .wb_dat_i    (dat),
            .wb_cti_i    (cti),
            .wb_dat_o    (dat_o[g]),
            .wb_ack_o    (ack[g]),
            .wb_err_o    (err[g]),
            .mem_adr_o   (madr[g]),
            .mem_be_o    (mbe[g]),
            .mem_wdata_o (mwd[g]),
            .mem_we_o    (mwe[g]),
            .mem_re_o    (mre[g]),
            .mem_rdata_i (rdata)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic any_out(input int k);
        return |{ack[k], err[k], dat_o[k], madr[k], mbe[k], mwd[k], mwe[k], mre[k]};
    endfunction

    // Drive one request, then watch both slaves for n cycles (c = cycles after the sampling edge).
    task automatic run(input vec_t v, input int n, input int drop_c, input bit keep_stb);
        for (int k = 0; k < 2; k++) begin
            ack_n[k] = 0; ack_c[k] = 0; err_n[k] = 0; err_c[k] = 0;
            str_n[k] = 0; str_c[k] = 0; both[k] = 0; leak[k] = 0;
            str_adr[k] = '0; dato_v[k] = '0; str_we[k] = 1'b0;
        end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr; sel = v.sel; dat = v.dat; rdata = v.rdata;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == drop_c) cyc = 1'b0;
            #1;
            for (int k = 0; k < 2; k++) begin
                if (ack[k]) begin ack_n[k]++; ack_c[k] = c; dato_v[k] = dat_o[k]; end
                if (err[k]) begin err_n[k]++; err_c[k] = c; end
                if (mwe[k] || mre[k]) begin str_n[k]++; str_c[k] = c; str_adr[k] = madr[k]; str_we[k] = mwe[k]; end
                if (ack[k] && err[k]) both[k]++;
                if (!ack[k] && dat_o[k] != '0) leak[k]++;
            end
            if (!keep_stb) stb = 1'b0;
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        for (int k = 0; k < 2; k++) begin
            string p;
            p = $sformatf("%s_w%0d", tag, 3 * k);
            if (v.err) begin
                chk({p, "_err_n"}, err_n[k], 1);
                chk({p, "_err_c"}, err_c[k], 2);
                chk({p, "_ack_n"}, ack_n[k], 0);
                chk({p, "_str_n"}, str_n[k], 0);
            end else begin
                chk({p, "_ack_n"}, ack_n[k], 1);
                chk({p, "_ack_c"}, ack_c[k], 2 + 3 * k);
                chk({p, "_err_n"}, err_n[k], 0);
                chk({p, "_str_n"}, str_n[k], 1);
                chk({p, "_str_c"}, str_c[k], 1);
                chk({p, "_str_we"}, str_we[k], v.we);
                chk({p, "_madr"}, str_adr[k], v.adr);
                chk({p, "_mbe"}, mbe[k], v.sel);
                chk({p, "_mwd"}, mwd[k], v.dat);
                chk({p, "_dato"}, dato_v[k], v.dato);
            end
            chk({p, "_ack_and_err"}, both[k], 0);
            chk({p, "_dato_leak"}, leak[k], 0);
        end
    endtask

    vec_t tv[7];
    vec_t va, vw, vc;
    logic [31:0] ra[4];
    int ac[4];
    int acks, res;

    initial begin
        tv[0] = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0, 32'h0};
        tv[1] = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         32'h1234_5678, 1'b0, 32'h1234_5678};
        tv[2] = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,         32'h9999_9999, 1'b1, 32'h0};
        tv[3] = '{1'b1, 32'h0000_0FFC, 4'h3, 32'hA5A5_0001, 32'h0000_0055, 1'b0, 32'h0};
        tv[4] = '{1'b0, 32'h0000_0FFC, 4'h8, 32'h0000_0007, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
        tv[5] = '{1'b1, 32'hFFFF_FFFC, 4'hF, 32'h1111_1111, 32'h0,         1'b1, 32'h0};
        tv[6] = '{1'b0, 32'h0000_0000, 4'h1, 32'h0,         32'h0000_0001, 1'b0, 32'h0000_0001};
        va    = '{1'b0, 32'h0000_0040, 4'hF, 32'h0,         32'h0000_0077, 1'b0, 32'h0};
        vw    = '{1'b1, 32'h0000_0084, 4'hC, 32'h3333_4444, 32'h0,         1'b0, 32'h0};
        vc    = '{1'b0, 32'h0000_0030, 4'hF, 32'h0,         32'h0000_0009, 1'b0, 32'h9};

        #3;
        for (int k = 0; k < 2; k++) chk($sformatf("reset_outs_w%0d", 3 * k), any_out(k), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run(tv[i], 8, 0, 1'b0);
            check_vec(tv[i], $sformatf("vec%0d", i));
        end

        // cyc dropped at c=2: slave 0 is in RESP, slave 3 is in WAIT; neither may terminate
        run(va, 2, 2, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("abort_ack_w%0d", 3 * k), ack_n[k], 0);
            chk($sformatf("abort_err_w%0d", 3 * k), err_n[k], 0);
            chk($sformatf("abort_str_w%0d", 3 * k), str_n[k], 1);
        end
        run(tv[0], 8, 0, 1'b0);
        check_vec(tv[0], "post_abort");

        // asynchronous reset while slave 3 waits
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h80; sel = 4'hF; dat = 32'h1111_2222;
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_reset_ack_w0", ack[0], 1);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("midreset_outs_w%0d", 3 * k), any_out(k), 0);
        cyc = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run(vw, 8, 0, 1'b0);
        check_vec(vw, "post_reset");

`ifdef WB_BURST_EN
        acks = 0; res = 0;
        cti = CTI_INCR;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h100; sel = 4'hF; rdata = 32'hB0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            #1;
            if (mre[0]) begin if (res < 4) ra[res] = madr[0]; res++; end
            if (ack[0]) begin
                if (acks < 4) ac[acks] = c;
                acks++;
                if (acks == 3) cti = CTI_END;
                if (acks == 4) stb = 1'b0;
            end
        end
        cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC;
        chk("burst_acks", acks, 4);
        chk("burst_reads", res, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("burst_adr%0d", i), ra[i], 32'h100 + 32'(4 * i));
            chk($sformatf("burst_ack_c%0d", i), ac[i], 2 + 2 * i);
        end
        repeat (8) @(negedge clk);
`else
        // cti=INCR is ignored: stb held high restarts only after a full IDLE cycle
        cti = CTI_INCR;
        run(vc, 4, 0, 1'b1);
        cti = CTI_CLASSIC;
        chk("cti_ign_str_n", str_n[0], 2);
        chk("cti_ign_str_c", str_c[0], 4);
        chk("cti_ign_ack_n", ack_n[0], 1);
        chk("cti_ign_ack_c", ack_c[0], 2);
        chk("cti_ign_dato", dato_v[0], 32'h9);
        repeat (8) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_slave_ctrl.md
Name: wb_slave_ctrl

Overview:
- Parametrised Wishbone B4 classic slave controller; successor to the fixed 2-bit slave FSM.
- Bridges a Wishbone master (processor data/instruction port) to a synchronous on-chip memory or peripheral register file.
- Adds configurable data/address width, programmable wait states, byte selects, address-range error response and optional incrementing bursts.

Parameters:
- DW, 32, data width in bits; multiple of 8.
- AW, 32, Wishbone address width in bits (byte address).
- WAIT_CYCLES, 0, extra wait states inserted between memory strobe and ack (0..15).
- MEM_BYTES, 4096, decoded slave size in bytes; addresses at or above it return error.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  transfer strobe.
- wb_we_i  in  1  1=write, 0=read.
- wb_adr_i  in  AW  byte address.
- wb_sel_i  in  DW/8  byte lane selects.
- wb_dat_i  in  DW  write data.
- wb_cti_i  in  3  cycle type (used only with burst feature).
- wb_dat_o  out  DW  read data; valid when wb_ack_o=1 on a read, else 0.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  error termination.
- mem_adr_o  out  AW  latched/incremented address to memory.
- mem_be_o  out  DW/8  latched byte enables.
- mem_wdata_o  out  DW  latched write data.
- mem_we_o  out  1  one-cycle write strobe.
- mem_re_o  out  1  one-cycle read strobe.
- mem_rdata_i  in  DW  read data; valid the cycle after mem_re_o, held until the next mem_re_o.

Behaviour:
- Reset (reset=0, async): state IDLE, all outputs 0, latched adr/sel/data/we cleared, wait counter 0.
- States are IDLE, ADR, WAIT, RESP, ERR, all registered.
- IDLE: on wb_cyc_i&wb_stb_i, latch adr, sel, dat, we, then go to ADR.
- ADR:
  - If latched adr >= MEM_BYTES, go to ERR; no memory strobe is issued.
  - Otherwise assert mem_we_o (write) or mem_re_o (read) for this one cycle, load counter=WAIT_CYCLES, then go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: decrement counter; go to RESP when counter reaches 1.
- RESP:
  - wb_ack_o = wb_cyc_i for exactly one cycle.
  - wb_dat_o = mem_rdata_i if read, else 0.
  - Then go to IDLE (burst case: see Optional Feature).
- ERR: wb_err_o = wb_cyc_i for one cycle; wb_ack_o stays 0; then go to IDLE.
- Latency: stb sampled at edge N gives ack during cycle N+2+WAIT_CYCLES.
- wb_ack_o and wb_err_o are never asserted together, and never for more than one consecutive cycle per transfer.
- wb_cyc_i deasserted in ADR or WAIT: abort to IDLE next edge, no ack/err. A write strobe already issued in ADR is not retracted.
- wb_stb_i dropping after the IDLE latch is ignored; the transfer completes, with ack gated only by cyc.
- Successive transfers: a new request is sampled only in IDLE, so at least one idle cycle separates non-burst transfers.
- mem_be_o and mem_wdata_o hold their latched values until the next latch; reads also drive mem_be_o from wb_sel_i.
- Reset asserted mid-transfer: immediate return to IDLE, all strobes low, no ack.

Optional Feature:
- Macro: WB_BURST_EN.
- Defined:
  - In RESP, if wb_cyc_i&wb_stb_i and latched cti==3'b010, the next state is ADR (not IDLE).
  - Internal address += DW/8; sel, we and dat are re-latched from the bus; wb_adr_i is not re-sampled.
  - cti==3'b111 or 3'b000 ends the burst and returns to IDLE.
  - An incremented address reaching MEM_BYTES takes the ERR path.
- Not defined: wb_cti_i is ignored and every beat is a full classic cycle through IDLE.

Decomposition:
- Shared package wb_pkg holds:
  - state encoding constants for IDLE/ADR/WAIT/RESP/ERR (3-bit);
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111.
- One natural sub-module: wb_wait_cnt (loadable down-counter with done flag) for the wait-state count.

Test Plan:
- WAIT_CYCLES=0, write adr=0x10, dat=0xDEADBEEF, sel=4'hF → mem_we_o pulse with mem_adr_o=0x10; ack 2 cycles after stb sampled; one-cycle ack.
- WAIT_CYCLES=3, read adr=0x20, mem_rdata_i=0x12345678 → mem_re_o single pulse; ack in cycle N+5 with wb_dat_o=0x12345678; wb_dat_o=0 before and after.
- Read adr=MEM_BYTES (0x1000) → wb_err_o one cycle at N+2; no mem_re_o; wb_ack_o stays 0.
- WAIT_CYCLES=4, drop wb_cyc_i during WAIT → FSM in IDLE next edge; no ack/err; next request accepted normally.
- Assert reset low mid-WAIT → all outputs 0 asynchronously; after release, a write completes with ack at N+2+WAIT_CYCLES.
- WB_BURST_EN defined: 4-beat read burst from 0x100, cti=010,010,010,111 → mem_adr_o=0x100,0x104,0x108,0x10C; 4 acks; no IDLE between beats; IDLE after the last.
